// File: rtl/sdram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wr_pkg
// Purpose  : Shared types and helpers for the multi-channel SDRAM burst
//            writer. Holds the burst FSM state encoding and the Avalon
//            burstcount width helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sdram_wr_pkg;

  // Burst engine states: wait for work, pick a channel, stream the burst.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2
  } wr_state_t;

  // Avalon burstcount must be able to represent BURST_LEN itself.
  function automatic int burstcount_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wr_fifo
// Purpose  : Single-clock show-ahead FIFO with occupancy count. The head
//            entry is always visible on rd_data; rd_en pops it. A write into
//            a full FIFO is accepted only when a pop happens in that cycle.
// Ports    : clk, rst_n    clock / asynchronous active-low reset
//            wr_en,wr_data write request and entry
//            rd_en         pop the head entry
//            rd_data       head entry (show-ahead)
//            count         number of stored entries (0..DEPTH)
// Revision : 1.0  initial release
// ============================================================================
module sdram_wr_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != FULL_CNT) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/sdram_mch_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_mch_burst_writer
// Purpose  : Multi-channel burst write engine for one HPS f2h_sdram Avalon-MM
//            write port. Each channel's word stream is buffered in its own
//            FIFO; full BURST_LEN bursts are granted round-robin and written
//            into a per-channel frame buffer (base + running offset).
//            Optional statistics counters are built when the macro
//            SDRAM_WR_STATS_EN is defined; otherwise they read as zero.
// Ports    : clk100, reset_n          clock / asynchronous active-low reset
//            ch_valid/ch_sof/ch_data  per-channel input words (ch0 in LSBs)
//            ch_base_addr             per-channel frame base word address
//            avm_*                    Avalon-MM burst write master
//            ch_overflow, sof_err     sticky per-channel error flags
//            frame_done               pulse after the last burst of a frame
//            stat_bursts, stat_stall  statistics counters
// Revision : 1.0  initial release
// ============================================================================
module sdram_mch_burst_writer
  import sdram_wr_pkg::*;
#(
  parameter int CH_NUM      = 2,
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 29,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int FRAME_WORDS = 259200
) (
  input  logic                                    clk100,
  input  logic                                    reset_n,
  input  logic [CH_NUM-1:0]                       ch_valid,
  input  logic [CH_NUM-1:0]                       ch_sof,
  input  logic [CH_NUM*DATA_W-1:0]                ch_data,
  input  logic [CH_NUM*ADDR_W-1:0]                ch_base_addr,
  output logic [ADDR_W-1:0]                       avm_address,
  output logic [burstcount_width(BURST_LEN)-1:0]  avm_burstcount,
  output logic [DATA_W-1:0]                       avm_writedata,
  output logic [DATA_W/8-1:0]                     avm_byteenable,
  output logic                                    avm_write,
  input  logic                                    avm_waitrequest,
  output logic [CH_NUM-1:0]                       ch_overflow,
  output logic [CH_NUM-1:0]                       sof_err,
  output logic [CH_NUM-1:0]                       frame_done,
  output logic [CH_NUM*32-1:0]                    stat_bursts,
  output logic [31:0]                             stat_stall
);

  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int BC_W   = burstcount_width(BURST_LEN);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ELIG_CNT  = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BLEN_A    = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Per-channel views
  fifo_entry_t       head       [CH_NUM];
  logic [CNT_W-1:0]  fifo_count [CH_NUM];
  logic [ADDR_W-1:0] base_arr   [CH_NUM];
  logic [ADDR_W-1:0] offset_q   [CH_NUM];
  logic [CH_NUM-1:0] eligible;
  logic [CH_NUM-1:0] pop;

  // Engine state
  wr_state_t         state_q;
  wr_state_t         state_d;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              beat_ok;
  logic              last_beat;
  logic              rr_found;
  logic [CH_W-1:0]   rr_sel;
  logic              wrap;

  // --------------------------------------------------------------------------
  // Per-channel input path: drop mode, burst phase, sticky flags, FIFO
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic                 take;
    logic                 full;
    logic                 wr;
    logic                 drop_q;
    logic                 ovf_q;
    logic                 serr_q;
    logic [BEAT_W-1:0]    phase_q;
    fifo_entry_t          wr_entry;

    assign base_arr[c] = ch_base_addr[c*ADDR_W +: ADDR_W];
    assign eligible[c] = (fifo_count[c] >= ELIG_CNT);
    assign pop[c]      = beat_ok && (grant_q == CH_W'(c));

    // In drop mode only a sof word is considered for writing.
    assign take = ch_valid[c] && (!drop_q || ch_sof[c]);
    // A same-cycle pop frees a slot, so the write still fits.
    assign full = (fifo_count[c] == FULL_CNT) && !pop[c];
    assign wr   = take && !full;

    assign wr_entry.sof  = ch_sof[c];
    assign wr_entry.data = ch_data[c*DATA_W +: DATA_W];

    assign ch_overflow[c] = ovf_q;
    assign sof_err[c]     = serr_q;

    always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
        drop_q  <= 1'b0;
        ovf_q   <= 1'b0;
        serr_q  <= 1'b0;
        phase_q <= '0;
      end else begin
        if (take && full) begin
          drop_q <= 1'b1;
          ovf_q  <= 1'b1;
        end
        if (wr) begin
          if (ch_sof[c]) begin
            drop_q  <= 1'b0;
            // The sof word itself is word 0 of the new phase.
            phase_q <= BEAT_W'(1);
            if (phase_q != '0) serr_q <= 1'b1;
          end else begin
            phase_q <= phase_q + BEAT_W'(1);
          end
        end
      end
    end

    sdram_wr_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk100),
      .rst_n   (reset_n),
      .wr_en   (wr),
      .wr_data (wr_entry),
      .rd_en   (pop[c]),
      .rd_data (head[c]),
      .count   (fifo_count[c])
    );
  end

  // --------------------------------------------------------------------------
  // Round-robin search, starting just after the last granted channel
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!rr_found && eligible[CH_W'(idx)]) begin
        rr_found = 1'b1;
        rr_sel   = CH_W'(idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Burst FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    avm_write = 1'b0;
    beat_ok   = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) state_d = ST_ARB;
      end
      ST_ARB: begin
        state_d = rr_found ? ST_BURST : ST_IDLE;
      end
      ST_BURST: begin
        avm_write = 1'b1;
        beat_ok   = !avm_waitrequest;
        if (beat_ok && (beat_cnt_q == BEAT_LAST)) begin
          last_beat = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wrap = ((offset_q[grant_q] + BLEN_A) == FRAME_A);

  // Grant, address, beat counter, frame offsets, frame_done pulse.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= '0;
      last_grant_q <= CH_W'(CH_NUM - 1);
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      frame_done   <= '0;
      for (int c = 0; c < CH_NUM; c++) offset_q[c] <= '0;
    end else begin
      frame_done <= '0;
      if ((state_q == ST_ARB) && rr_found) begin
        grant_q      <= rr_sel;
        last_grant_q <= rr_sel;
        beat_cnt_q   <= '0;
        // A sof at the burst head restarts the frame at the base address.
        if (head[rr_sel].sof) begin
          offset_q[rr_sel] <= '0;
          addr_q           <= base_arr[rr_sel];
        end else begin
          addr_q           <= base_arr[rr_sel] + offset_q[rr_sel];
        end
      end
      if (beat_ok) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      if (last_beat) begin
        if (wrap) begin
          offset_q[grant_q]   <= '0;
          frame_done[grant_q] <= 1'b1;
        end else begin
          offset_q[grant_q]   <= offset_q[grant_q] + BLEN_A;
        end
      end
    end
  end

  assign avm_address    = addr_q;
  assign avm_burstcount = avm_write ? BC_W'(BURST_LEN) : '0;
  assign avm_writedata  = avm_write ? head[grant_q].data : '0;
  assign avm_byteenable = '1;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef SDRAM_WR_STATS_EN
  logic [31:0] stall_q;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_stat
    logic [31:0] bursts_q;
    always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n)                                    bursts_q <= '0;
      else if (last_beat && (grant_q == CH_W'(c)))     bursts_q <= bursts_q + 32'd1;
    end
    assign stat_bursts[c*32 +: 32] = bursts_q;
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n)                         stall_q <= '0;
    else if (avm_write && avm_waitrequest) stall_q <= stall_q + 32'd1;
  end
  assign stat_stall = stall_q;
`else
  assign stat_bursts = '0;
  assign stat_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_mch_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_mch_burst_writer
// Purpose  : Directed self-checking bench for sdram_mch_burst_writer with
//            CH_NUM=2, BURST_LEN=16, FIFO_DEPTH=64, FRAME_WORDS=32.
//            Accepted beats are logged at the falling edge and compared with
//            hand-computed addresses and data.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_mch_burst_writer;

  localparam int CH_NUM      = 2;
  localparam int DATA_W      = 64;
  localparam int ADDR_W      = 29;
  localparam int BURST_LEN   = 16;
  localparam int FIFO_DEPTH  = 64;
  localparam int FRAME_WORDS = 32;
  localparam int BC_W        = $clog2(BURST_LEN) + 1;

  logic                       clk100 = 1'b0;
  logic                       reset_n;
  logic [CH_NUM-1:0]          ch_valid;
  logic [CH_NUM-1:0]          ch_sof;
  logic [CH_NUM*DATA_W-1:0]   ch_data;
  logic [CH_NUM*ADDR_W-1:0]   ch_base_addr;
  logic [ADDR_W-1:0]          avm_address;
  logic [BC_W-1:0]            avm_burstcount;
  logic [DATA_W-1:0]          avm_writedata;
  logic [DATA_W/8-1:0]        avm_byteenable;
  logic                       avm_write;
  logic                       avm_waitrequest;
  logic [CH_NUM-1:0]          ch_overflow;
  logic [CH_NUM-1:0]          sof_err;
  logic [CH_NUM-1:0]          frame_done;
  logic [CH_NUM*32-1:0]       stat_bursts;
  logic [31:0]                stat_stall;

  sdram_mch_burst_writer #(
    .CH_NUM      (CH_NUM),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .clk100          (clk100),
    .reset_n         (reset_n),
    .ch_valid        (ch_valid),
    .ch_sof          (ch_sof),
    .ch_data         (ch_data),
    .ch_base_addr    (ch_base_addr),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest),
    .ch_overflow     (ch_overflow),
    .sof_err         (sof_err),
    .frame_done      (frame_done),
    .stat_bursts     (stat_bursts),
    .stat_stall      (stat_stall)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Beat log and frame_done pulse counters.
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  int bc_bad = 0;
  int fd_cnt [CH_NUM];

  always @(negedge clk100) begin
    if (avm_write && !avm_waitrequest) begin
      log_addr.push_back(avm_address);
      log_data.push_back(avm_writedata);
      if (avm_burstcount != BC_W'(BURST_LEN)) bc_bad++;
    end
    for (int c = 0; c < CH_NUM; c++) if (frame_done[c]) fd_cnt[c]++;
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic send(input int ch, input logic sof, input logic [DATA_W-1:0] d);
    ch_valid[ch] = 1'b1;
    ch_sof[ch]   = sof;
    ch_data[ch*DATA_W +: DATA_W] = d;
    tick();
    ch_valid[ch] = 1'b0;
    ch_sof[ch]   = 1'b0;
  endtask

  task automatic send_both(input logic s0, input logic [DATA_W-1:0] d0,
                           input logic s1, input logic [DATA_W-1:0] d1);
    ch_valid = 2'b11;
    ch_sof   = {s1, s0};
    ch_data  = {d1, d0};
    tick();
    ch_valid = 2'b00;
    ch_sof   = 2'b00;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int b;
    b = 0;
    while (log_data.size() < n && b < 2000) begin
      tick();
      b++;
    end
    chk(tag, 64'(log_data.size()), 64'(n));
  endtask

  task automatic check_burst(input int idx, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] d0, input string tag);
    for (int i = 0; i < BURST_LEN; i++) begin
      chk({tag, "_addr"}, 64'(log_addr[idx+i]), 64'(addr));
      chk({tag, "_data"}, log_data[idx+i], d0 + DATA_W'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    int b;

    reset_n         = 1'b0;
    ch_valid        = '0;
    ch_sof          = '0;
    ch_data         = '0;
    avm_waitrequest = 1'b0;
    ch_base_addr    = {29'h2000, 29'h100};

    // Reset state
    repeat (2) tick();
    chk("rst_write",      64'(avm_write),      64'd0);
    chk("rst_bcount",     64'(avm_burstcount), 64'd0);
    chk("rst_address",    64'(avm_address),    64'd0);
    chk("rst_wdata",      avm_writedata,       64'd0);
    chk("rst_byteen",     64'(avm_byteenable), 64'hFF);
    chk("rst_flags",      64'({ch_overflow, sof_err, frame_done}), 64'd0);
    reset_n = 1'b1;
    tick();

    // T1: single burst on ch0, latency t -> t+2
    for (int i = 0; i < 16; i++) send(0, i == 0, 64'hA000 + 64'(i));
    chk("lat_t0_write", 64'(avm_write), 64'd0);
    tick();
    chk("lat_t1_write", 64'(avm_write), 64'd0);
    tick();
    chk("lat_t2_write",   64'(avm_write),      64'd1);
    chk("lat_t2_address", 64'(avm_address),    64'h100);
    chk("lat_t2_bcount",  64'(avm_burstcount), 64'd16);
    chk("lat_t2_wdata",   avm_writedata,       64'hA000);
    wait_beats(16, "t1_beats");
    check_burst(0, 29'h100, 64'hA000, "t1");

    // T2: second ch0 burst (offset 16) with a 5-cycle stall on beat 3
    for (int i = 0; i < 16; i++) send(0, 1'b0, 64'hA100 + 64'(i));
    b = 0;
    while (log_data.size() < 19 && b < 200) begin
      tick();
      b++;
    end
    chk("t2_reach_beat3", 64'(log_data.size()), 64'd19);
    avm_waitrequest = 1'b1;
    hold_addr = avm_address;
    hold_data = avm_writedata;
    chk("t2_stall_addr0", 64'(hold_addr), 64'h110);
    chk("t2_stall_data0", hold_data,      64'hA103);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_write", 64'(avm_write),   64'd1);
      chk("t2_stall_addr",  64'(avm_address), 64'h110);
      chk("t2_stall_data",  avm_writedata,    64'hA103);
    end
    avm_waitrequest = 1'b0;
    wait_beats(32, "t2_beats");
    tick();
    check_burst(16, 29'h110, 64'hA100, "t2");
    chk("t2_frame_done", 64'(fd_cnt[0]), 64'd1);
`ifdef SDRAM_WR_STATS_EN
    chk("t2_stat_stall",  64'(stat_stall),        64'd5);
    chk("t2_stat_bursts", 64'(stat_bursts[31:0]), 64'd2);
`else
    chk("t2_stat_stall",  64'(stat_stall),  64'd0);
    chk("t2_stat_bursts", 64'(stat_bursts), 64'd0);
`endif

    // T3: both channels loaded together; last grant was ch0 so ch1 leads
    for (int i = 0; i < 32; i++)
      send_both(1'b0, 64'hB000 + 64'(i), i == 0, 64'hC000 + 64'(i));
    wait_beats(96, "t3_beats");
    tick();
    check_burst(32, 29'h2000, 64'hC000, "t3_ch1_b0");
    check_burst(48, 29'h100,  64'hB000, "t3_ch0_b0");
    check_burst(64, 29'h2010, 64'hC010, "t3_ch1_b1");
    check_burst(80, 29'h110,  64'hB010, "t3_ch0_b1");
    chk("t3_fd_ch0", 64'(fd_cnt[0]), 64'd2);
    chk("t3_fd_ch1", 64'(fd_cnt[1]), 64'd1);

    // T4: sof mid-phase on ch1 -> sof_err, burst spans both frames
    for (int i = 0; i < 16; i++) send(1, i == 5, 64'hE000 + 64'(i));
    chk("t4_sof_err", 64'(sof_err), 64'b10);
    wait_beats(112, "t4_beats");
    check_burst(96, 29'h2000, 64'hE000, "t4");

    // T5: overflow with waitrequest stuck, drop until sof
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 65; i++) send(0, 1'b0, 64'hD000 + 64'(i));
    chk("t5_overflow", 64'(ch_overflow), 64'b01);
    send(0, 1'b0, 64'hDEAD);
    avm_waitrequest = 1'b0;
    wait_beats(176, "t5_drain");
    check_burst(112, 29'h100, 64'hD000, "t5_b0");
    check_burst(128, 29'h110, 64'hD010, "t5_b1");
    check_burst(144, 29'h100, 64'hD020, "t5_b2");
    check_burst(160, 29'h110, 64'hD030, "t5_b3");
    send(0, 1'b0, 64'hEEEE);
    for (int i = 0; i < 16; i++) send(0, i == 0, 64'hF000 + 64'(i));
    wait_beats(192, "t5_resync");
    check_burst(176, 29'h100, 64'hF000, "t5_sof");

    // T6: head sof restarts the frame although offset is 16
    for (int i = 0; i < 16; i++) send(0, i == 0, 64'hF100 + 64'(i));
    wait_beats(208, "t6_beats");
    check_burst(192, 29'h100, 64'hF100, "t6");
    chk("t6_log_size", 64'(log_data.size()), 64'd208);

    // T7: reset in the middle of a stalled burst
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 16; i++) send(1, i == 0, 64'h9000 + 64'(i));
    b = 0;
    while (!avm_write && b < 50) begin
      tick();
      b++;
    end
    chk("t7_burst_started", 64'(avm_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_async_write", 64'(avm_write),   64'd0);
    chk("t7_rst_address", 64'(avm_address), 64'd0);
    chk("t7_rst_flags",   64'({ch_overflow, sof_err}), 64'd0);
    @(posedge clk100);
    #1;
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    repeat (5) tick();
    chk("t7_idle_after", 64'(avm_write), 64'd0);
    chk("burstcount_all", 64'(bc_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
